// File: rtl/traffic_time_cfg.sv
// Front-panel configuration stage: debounces three active-low keys and runs a small edit FSM
// that adjusts the green/red and yellow phase durations fed to the traffic-light controller.
module traffic_time_cfg #(
  parameter int unsigned DEB_CYCLES       = 240_000,
  parameter int unsigned REPEAT_DELAY_CYC = 6_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 1_200_000,
  parameter int unsigned GREEN_DEFAULT    = 7,
  parameter int unsigned GREEN_MIN        = 3,
  parameter int unsigned GREEN_MAX        = 99,
  parameter int unsigned YELLOW_DEFAULT   = 5,
  parameter int unsigned YELLOW_MIN       = 1,
  parameter int unsigned YELLOW_MAX       = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode_i,
  input  logic        key_up_i,
  input  logic        key_down_i,
  output logic [10:0] rg_cnt_set_o,
  output logic [10:0] y_cnt_set_o,
  output logic        night_o,
  output logic        edit_active_o,
  output logic        edit_sel_o,
  output logic [6:0]  disp_val_o,
  output logic        apply_pulse_o
);

  localparam int unsigned DebW   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned RepMax = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                   REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  localparam logic [6:0] GDef = 7'(GREEN_DEFAULT);
  localparam logic [6:0] GMin = 7'(GREEN_MIN);
  localparam logic [6:0] GMax = 7'(GREEN_MAX);
  localparam logic [6:0] YDef = 7'(YELLOW_DEFAULT);
  localparam logic [6:0] YMin = 7'(YELLOW_MIN);
  localparam logic [6:0] YMax = 7'(YELLOW_MAX);

  typedef enum logic [1:0] {StRun, StSetG, StSetY} state_e;

  state_e     state_q, state_d;
  logic [6:0] shadow_g_q, shadow_g_d;
  logic [6:0] shadow_y_q, shadow_y_d;
  logic [6:0] rg_q, rg_d;
  logic [6:0] y_q, y_d;
  logic       night_q, night_d;
  logic       apply_q, apply_d;

  logic [2:0] key_raw;
  logic [2:0] key_level;
  logic [2:0] key_press;
  logic [2:0] rep_ev;
  logic       editing;

  // Bit 0 = mode, bit 1 = up, bit 2 = down.
  assign key_raw = {key_down_i, key_up_i, key_mode_i};
  assign editing = (state_q != StRun);

  for (genvar k = 0; k < 3; k++) begin : g_key
    logic            sync1_q, sync2_q, level_q, level_prev_q;
    logic [DebW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q      <= 1'b1;
        sync2_q      <= 1'b1;
        level_q      <= 1'b1;
        level_prev_q <= 1'b1;
        cnt_q        <= '0;
      end else begin
        sync1_q      <= key_raw[k];
        sync2_q      <= sync1_q;
        level_prev_q <= level_q;
        if (sync2_q == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DebW'(DEB_CYCLES - 1)) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + DebW'(1);
        end
      end
    end

    assign key_level[k] = level_q;
    assign key_press[k] = level_prev_q & ~level_q;
  end

  assign rep_ev[0] = 1'b0;

  // Counter value equals cycles elapsed since the press event (or since the last repeat).
  for (genvar k = 1; k < 3; k++) begin : g_rep
    logic [RepW-1:0] cnt_q;
    logic            armed_q;
    logic            fire;

    assign fire = editing & ~key_level[k] &
                  (cnt_q == (armed_q ? RepW'(REPEAT_RATE_CYC) : RepW'(REPEAT_DELAY_CYC)));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        armed_q <= 1'b0;
      end else if (!editing || key_level[k]) begin
        cnt_q   <= '0;
        armed_q <= 1'b0;
      end else if (fire) begin
        cnt_q   <= RepW'(1);
        armed_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + RepW'(1);
      end
    end

    assign rep_ev[k] = fire;
  end

  logic mode_ev, up_ev, dn_ev, inc, dec;

  assign mode_ev = key_press[0];
  assign up_ev   = key_press[1] | rep_ev[1];
  assign dn_ev   = key_press[2] | rep_ev[2];
  // Mode wins; simultaneous up and down cancel.
  assign inc     = up_ev & ~dn_ev & ~mode_ev;
  assign dec     = dn_ev & ~up_ev & ~mode_ev;

  always_comb begin
    state_d    = state_q;
    shadow_g_d = shadow_g_q;
    shadow_y_d = shadow_y_q;
    rg_d       = rg_q;
    y_d        = y_q;
    night_d    = night_q;
    apply_d    = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mode_ev) begin
          state_d    = StSetG;
          shadow_g_d = rg_q;
          shadow_y_d = y_q;
        end else if (inc) begin
          night_d = ~night_q;
        end
      end
      StSetG: begin
        if (mode_ev) begin
          state_d = StSetY;
        end else if (inc && shadow_g_q < GMax) begin
          shadow_g_d = shadow_g_q + 7'd1;
        end else if (dec && shadow_g_q > GMin) begin
          shadow_g_d = shadow_g_q - 7'd1;
        end
      end
      StSetY: begin
        if (mode_ev) begin
          state_d = StRun;
          rg_d    = shadow_g_q;
          y_d     = shadow_y_q;
          apply_d = 1'b1;
        end else if (inc && shadow_y_q < YMax) begin
          shadow_y_d = shadow_y_q + 7'd1;
        end else if (dec && shadow_y_q > YMin) begin
          shadow_y_d = shadow_y_q - 7'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      shadow_g_q <= '0;
      shadow_y_q <= '0;
      rg_q       <= GDef;
      y_q        <= YDef;
      night_q    <= 1'b0;
      apply_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_g_q <= shadow_g_d;
      shadow_y_q <= shadow_y_d;
      rg_q       <= rg_d;
      y_q        <= y_d;
      night_q    <= night_d;
      apply_q    <= apply_d;
    end
  end

  assign rg_cnt_set_o  = {4'b0000, rg_q};
  assign y_cnt_set_o   = {4'b0000, y_q};
  assign night_o       = night_q;
  assign edit_active_o = editing;
  assign edit_sel_o    = (state_q == StSetY);
  assign apply_pulse_o = apply_q;

  always_comb begin
    disp_val_o = '0;
    if (state_q == StSetG) disp_val_o = shadow_g_q;
    else if (state_q == StSetY) disp_val_o = shadow_y_q;
  end

endmodule

// File: doc/traffic_time_cfg.md
# traffic_time_cfg

- Front-panel configuration stage that sits directly upstream of the traffic-light controller.
- Debounces three raw push-buttons and provides a small edit state machine for changing the green/red and yellow phase durations.
- Drives the controller's `rg_cnt_set`, `y_cnt_set` and night-mode inputs, and supplies a value for the 7-segment path while editing.

## Interface
- `DEB_CYCLES`, 240_000: consecutive stable cycles required to accept a key level (20 ms at 12 MHz).
- `REPEAT_DELAY_CYC`, 6_000_000: hold time from press event to first auto-repeat.
- `REPEAT_RATE_CYC`, 1_200_000: interval between subsequent auto-repeats.
- `GREEN_DEFAULT`, 7; `GREEN_MIN`, 3; `GREEN_MAX`, 99: green/red duration in seconds.
- `YELLOW_DEFAULT`, 5; `YELLOW_MIN`, 1; `YELLOW_MAX`, 9: yellow duration in seconds.
- `clk` in 1: system clock (12 MHz).
- `rst_n` in 1: reset, asynchronous, active-low.
- `key_mode` in 1: raw button, active-low, asynchronous to `clk`.
- `key_up` in 1: raw button, active-low, asynchronous.
- `key_down` in 1: raw button, active-low, asynchronous.
- `rg_cnt_set` out 11: committed green/red duration.
- `y_cnt_set` out 11: committed yellow duration.
- `night` out 1: night-mode request to the controller.
- `edit_active` out 1: high in SET_G or SET_Y.
- `edit_sel` out 1: 0 = editing green, 1 = editing yellow; 0 in RUN.
- `disp_val` out 7: shadow value being edited; 0 in RUN.
- `apply_pulse` out 1: one-cycle strobe when new durations are committed.

## Operation
**Key path**, per key, identical logic:
- 2-flop synchronizer.
- Debounce counter:
  - clears whenever the synchronized level equals the debounced level;
  - otherwise increments;
  - when it reaches DEB_CYCLES-1 while still differing, the debounced level flips on the next edge and the counter clears.
- Debounced level resets to released (1).
- Press event: one-cycle pulse on a debounced 1→0 transition.

**Auto-repeat** (up/down only, only in SET_G/SET_Y):
- While the debounced level stays low, an extra event fires REPEAT_DELAY_CYC cycles after the press event.
- Further events then fire every REPEAT_RATE_CYC cycles.
- Release stops repeating immediately; the repeat counter clears.

**Edit FSM**, states RUN, SET_G, SET_Y:
- RUN:
  - mode event → SET_G; shadow_g ← rg_cnt_set, shadow_y ← y_cnt_set.
  - up event → toggles `night`.
  - down event → ignored.
- SET_G:
  - up → shadow_g+1, saturating at GREEN_MAX.
  - down → shadow_g-1, saturating at GREEN_MIN.
  - mode → SET_Y.
- SET_Y:
  - up/down → same rules on shadow_y with YELLOW_MIN/YELLOW_MAX.
  - mode → RUN: rg_cnt_set ← shadow_g, y_cnt_set ← shadow_y, apply_pulse=1 for exactly that cycle.

**Event priority and collisions:**
- Mode event wins over an up/down event in the same cycle; the up/down event is discarded.
- Up and down events in the same cycle are both discarded.

**Output behaviour:**
- Committed outputs and `night` are unchanged throughout editing; `night` persists across edit sessions.
- `disp_val` = shadow_g in SET_G, shadow_y in SET_Y, 0 in RUN.

**Widths:**
- Shadow registers are 7 bits; committed outputs are zero-extended to 11 bits.
- MAX parameters must be ≤ 99 and MIN ≥ 1.
- All arithmetic clamps; no wrap-around.

## Timing
**Reset values** (asynchronous assertion, applied immediately):
- rg_cnt_set = GREEN_DEFAULT, y_cnt_set = YELLOW_DEFAULT.
- night = 0, edit_active = 0, edit_sel = 0, disp_val = 0, apply_pulse = 0.
- FSM in RUN, shadows cleared, debounced levels = 1, all counters = 0.

**Latency and ordering:**
- Raw edge → press event: DEB_CYCLES+3 clocks, with ±1 cycle tolerance for asynchronous sampling.
- Event → register update (night, shadow, state, committed outputs): next clock edge.
- apply_pulse is coincident with the committed-output change.

**Boundary cases:**
- Bounce glitches shorter than DEB_CYCLES produce no event.
- Reset mid-edit discards the shadows, returns to RUN with defaults, and produces no apply_pulse.
- No edit timeout: the FSM stays in SET_G or SET_Y until a mode event.

## Test plan
Test parameters for all scenarios: DEB_CYCLES=4, REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=5.

1. **Reset:** assert rst_n mid-clock → outputs 7/5/night 0/edit_active 0/apply_pulse 0 immediately.
2. **Bounce rejection:** key_up low for 2 cycles, repeated 3 times with 2-cycle high gaps, in RUN → night stays 0. Then key_up held low for 12 cycles → night=1 at 7±1 cycles after the falling edge.
3. **Edit session:** mode, up×3, mode, down×10, mode (each a clean press) → rg_cnt_set=10, y_cnt_set=1 (yellow saturates at MIN). apply_pulse high for one cycle. Outputs read 7/5 until that cycle; disp_val tracks the shadows (8, 9, 10, then 4…1).
4. **Auto-repeat:** in SET_G, key_up debounced-low for 42 cycles → events at +0, +20, +25, +30, +35, +40 → disp_val=13. Release → no further change.
5. **Saturation and collisions:**
   - GREEN_MAX=10, in SET_G hold up → disp_val stops at 10.
   - up and down events in the same cycle → no change.
   - mode and up events in the same cycle → state advances to SET_Y, no increment.
6. **Reset mid-edit:** in SET_Y with shadow_y=9, pulse rst_n low → RUN, y_cnt_set=5, apply_pulse never asserted, night=0.
